branch_resolve: RTL
===================

BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 Parameter IDX_W, default 5, SHALL set the predictor table index width.
REQ-002 Parameter DEPTH, default 2, SHALL set the number of in-flight prediction record stages (IF/ID, ID/EX).
REQ-003 Timing and reset SHALL be one clock; reset is synchronous and active-low.
REQ-004 clk  input  1  SHALL be the sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  SHALL be the synchronous active-low reset.
REQ-006 if_valid  input  1  SHALL mark a fetched instruction entering the record pipe.
REQ-007 if_pc / if_pred_pc  input  32 each  SHALL carry the fetch PC and the predicted next PC.
REQ-008 if_pred_taken  input  1  SHALL carry the predictor's taken bit.
REQ-009 if_pred_index  input  IDX_W  SHALL carry the table index used for the prediction.
REQ-010 stall  input  1  SHALL freeze the record pipe.
REQ-011 ex_is_branch / ex_is_jump  input  1 each  SHALL classify the instruction at the EX end of the pipe.
REQ-012 ex_cond_true  input  1  SHALL carry the resolved branch condition; ex_target  input  32  SHALL carry the resolved target.
REQ-013 btb_update  output  1, write_index  output  IDX_W, tag_write  output  32, real_pc  output  32 SHALL drive the predictor's table write port.
REQ-014 real_taken  output  2  SHALL encode outcome: 2'b01 taken, 2'b00 not taken, 2'b10 no update.
REQ-015 redirect  output  1, redirect_pc  output  32  SHALL request a fetch correction.
REQ-016 br_count / mis_count  output  32 each  SHALL count resolved control instructions and mispredictions.

Function
REQ-017 Record pipe SHALL shift {valid, pc, pred_taken, pred_pc, index} one stage per cycle when stall=0 and SHALL hold all stages when stall=1.
REQ-018 The EX record (last stage) SHALL be resolved combinationally and its results registered, giving 1-cycle latency from EX to all outputs.
REQ-019 Actual next PC SHALL be ex_target if (ex_is_jump | (ex_is_branch & ex_cond_true)), else pc+4 (modulo 2^32).
REQ-020 Mispredict SHALL be flagged when EX record valid and actual next PC != pred_pc.
REQ-021 On mispredict: redirect=1 and redirect_pc=actual next PC for exactly one cycle; all younger records SHALL be invalidated in the same edge.
REQ-022 For a valid branch/jump with actual taken: btb_update=1, write_index=index, tag_write=pc, real_pc=ex_target, real_taken=2'b01.
REQ-023 For a valid branch not taken: btb_update=0, real_taken=2'b00.
REQ-024 Non-control or invalid EX record: btb_update=0, real_taken=2'b10, redirect=0.
REQ-025 During stall, outputs SHALL be held at the no-update state (btb_update=0, real_taken=2'b10, redirect=0); resolution SHALL occur once, in the first non-stalled cycle.
REQ-026 br_count SHALL increment per valid resolved branch/jump; mis_count per mispredict; both wrap at 2^32.
REQ-027 A redirect cycle SHALL take priority over a simultaneous if_valid: the incoming record SHALL be dropped.

Reset
REQ-028 reset=0 at a clock edge SHALL clear all record valid bits, counters, btb_update, redirect, write_index, tag_write, real_pc, redirect_pc to 0 and set real_taken=2'b10.
REQ-029 Reset asserted mid-operation SHALL discard in-flight records with no predictor write or redirect issued.

Structure
REQ-030 Shared package SHALL hold the real_taken encodings (TAKEN, NOT_TAKEN, NO_UPD), the prediction record struct and IDX_W default.
REQ-031 One sub-module, pred_record_pipe (parameterised by DEPTH, with stall and flush), SHALL hold the record stages.

Verification
REQ-032 Branch at pc 0x40, pred not taken, cond true, target 0x80 -> next cycle btb_update=1, write_index=idx, tag_write=0x40, real_pc=0x80, real_taken=01, redirect=1, redirect_pc=0x80.
REQ-033 Branch at 0x40, pred taken to 0x80, cond false -> real_taken=00, redirect=1, redirect_pc=0x44, younger record invalid.
REQ-034 Correctly predicted taken branch -> btb_update=1, redirect=0, br_count+1, mis_count unchanged.
REQ-035 stall=1 for 3 cycles with branch in EX -> outputs held at no-update; single resolution after release.
REQ-036 reset=0 with mispredicting branch in ID/EX -> no redirect, counters 0, real_taken=10 after release.
REQ-037 mis_count preset-driven to 0xFFFFFFFF then mispredict -> mis_count=0.

Source files
------------

// File: rtl/branch_resolve_pkg.sv
// Shared types and encodings for branch resolution and the prediction record pipe.
package branch_resolve_pkg;

  localparam int unsigned IDX_W_DEF = 5;
  // Widest predictor index a record can carry; IDX_W must not exceed this.
  localparam int unsigned IDX_MAX_W = 16;
  localparam int unsigned PC_W      = 32;

  typedef enum logic [1:0] {
    NOT_TAKEN = 2'b00,
    TAKEN     = 2'b01,
    NO_UPD    = 2'b10
  } real_taken_e;

  typedef struct packed {
    logic                 valid;
    logic [PC_W-1:0]      pc;
    logic                 pred_taken;
    logic [PC_W-1:0]      pred_pc;
    logic [IDX_MAX_W-1:0] index;
  } pred_rec_t;

endpackage

// File: rtl/branch_resolve_pred_record_pipe.sv
// Prediction record stages from fetch to EX; stall holds, flush invalidates all.
module pred_record_pipe
  import branch_resolve_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      stall,
  input  logic      flush,
  input  pred_rec_t in_rec,
  output pred_rec_t ex_rec
);

  pred_rec_t stage [DEPTH];

  // Shift one stage per unstalled cycle; only valid bits need clearing.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) stage[i].valid <= 1'b0;
    end else if (flush) begin
      for (int i = 0; i < int'(DEPTH); i++) stage[i].valid <= 1'b0;
    end else if (!stall) begin
      stage[0] <= in_rec;
      for (int i = 1; i < int'(DEPTH); i++) stage[i] <= stage[i-1];
    end
  end

  assign ex_rec = stage[DEPTH-1];

endmodule

// File: rtl/branch_resolve.sv
// Resolves the EX prediction record against the real outcome and drives
// predictor updates, fetch redirects and statistics counters.
module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter int unsigned IDX_W = IDX_W_DEF,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             if_valid,
  input  logic [31:0]      if_pc,
  input  logic [31:0]      if_pred_pc,
  input  logic             if_pred_taken,
  input  logic [IDX_W-1:0] if_pred_index,
  input  logic             stall,
  input  logic             ex_is_branch,
  input  logic             ex_is_jump,
  input  logic             ex_cond_true,
  input  logic [31:0]      ex_target,
  output logic             btb_update,
  output logic [IDX_W-1:0] write_index,
  output logic [31:0]      tag_write,
  output logic [31:0]      real_pc,
  output logic [1:0]       real_taken,
  output logic             redirect,
  output logic [31:0]      redirect_pc,
  output logic [31:0]      br_count,
  output logic [31:0]      mis_count
);

  pred_rec_t   in_rec;
  pred_rec_t   ex_rec;
  logic        ctrl_c;
  logic        taken_c;
  logic        mis_c;
  logic [31:0] actual_c;
  logic        unused_bits;

  // Record fields carried for the predictor but not needed to resolve.
  assign unused_bits = ^{ex_rec.pred_taken, ex_rec.index};

  // Resolve the EX record; stalled cycles never resolve.
  always_comb begin
    ctrl_c   = 1'b0;
    taken_c  = 1'b0;
    mis_c    = 1'b0;
    actual_c = ex_rec.pc + 32'd4;
    taken_c  = ex_is_jump | (ex_is_branch & ex_cond_true);
    ctrl_c   = !stall & ex_rec.valid & (ex_is_branch | ex_is_jump);
    if (taken_c) actual_c = ex_target;
    mis_c    = ctrl_c & (actual_c != ex_rec.pred_pc);
  end

  // Incoming record; wrong-path fetches during a flush or redirect are dropped.
  always_comb begin
    in_rec            = '0;
    in_rec.valid      = if_valid & !mis_c & !redirect;
    in_rec.pc         = if_pc;
    in_rec.pred_taken = if_pred_taken;
    in_rec.pred_pc    = if_pred_pc;
    in_rec.index      = IDX_MAX_W'(if_pred_index);
  end

  pred_record_pipe #(.DEPTH(DEPTH)) u_pipe (
    .clk    (clk),
    .reset  (reset),
    .stall  (stall),
    .flush  (mis_c),
    .in_rec (in_rec),
    .ex_rec (ex_rec)
  );

  // Registered resolution results; pulses default to the no-update state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      btb_update  <= 1'b0;
      write_index <= '0;
      tag_write   <= '0;
      real_pc     <= '0;
      real_taken  <= NO_UPD;
      redirect    <= 1'b0;
      redirect_pc <= '0;
      br_count    <= '0;
      mis_count   <= '0;
    end else begin
      btb_update <= 1'b0;
      real_taken <= NO_UPD;
      redirect   <= 1'b0;
      if (ctrl_c) begin
        br_count   <= br_count + 32'd1;
        real_taken <= taken_c ? TAKEN : NOT_TAKEN;
        if (taken_c) begin
          btb_update  <= 1'b1;
          write_index <= IDX_W'(ex_rec.index);
          tag_write   <= ex_rec.pc;
          real_pc     <= ex_target;
        end
      end
      if (mis_c) begin
        redirect    <= 1'b1;
        redirect_pc <= actual_c;
        mis_count   <= mis_count + 32'd1;
      end
    end
  end

endmodule
